// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between the UART receiver, the receive FIFO and the transmit side.
// The master side produces bytes and consumes the head; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  push;
  logic [7:0]            wdata;
  logic                  pop;
  logic                  flag_clr;
  logic [7:0]            rdata;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, wdata, pop, flag_clr,
    input  rdata, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, wdata, pop, flag_clr,
    output rdata, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver.
// It keeps sticky overflow/underflow flags that record dropped pushes and illegal pops.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_fifo_if.slave    bus
);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int COUNT_W = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [COUNT_W-1:0]    count;
  logic                  overflow;
  logic                  underflow;

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;
  logic set_overflow;
  logic set_underflow;

  always_comb begin
    empty         = (count == '0);
    full          = (count == COUNT_W'(DEPTH));
    // A pop frees the head slot in the same edge, so a full FIFO still takes the push
    do_push       = bus.push && (!full || bus.pop);
    do_pop        = bus.pop && !empty;
    set_overflow  = bus.push && full && !bus.pop;
    set_underflow = bus.pop && empty;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + COUNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - COUNT_W'(1);
      end
    end
  end

  // A new event beats a simultaneous clear so no drop goes unrecorded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (set_overflow) begin
        overflow <= 1'b1;
      end else if (bus.flag_clr) begin
        overflow <= 1'b0;
      end
      if (set_underflow) begin
        underflow <= 1'b1;
      end else if (bus.flag_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rdata     = empty ? 8'h00 : mem[rd_ptr];
    bus.empty     = empty;
    bus.full      = full;
    bus.count     = count;
    bus.overflow  = overflow;
    bus.underflow = underflow;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, pointer wrap, full/empty corner cases,
// sticky flag behaviour and asynchronous reset in the middle of traffic.
module tb_uart_rx_fifo;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one clock cycle of inputs and returns 1 ns after the rising edge
  task automatic applyStimulus(input logic push, input logic [7:0] wdata,
                               input logic pop, input logic flag_clr);
    bus.push     = push;
    bus.wdata    = wdata;
    bus.pop      = pop;
    bus.flag_clr = flag_clr;
    @(posedge clk);
    #1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.flag_clr = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    bus.push     = 1'b0;
    bus.wdata    = 8'h00;
    bus.pop      = 1'b0;
    bus.flag_clr = 1'b0;
    rst          = 1'b1;
    #23;
    rst = 1'b0;
    @(posedge clk);
    #1;

    checkOutput("reset_empty", bus.empty, 1);
    checkOutput("reset_full", bus.full, 0);
    checkOutput("reset_count", bus.count, 0);
    checkOutput("reset_rdata", bus.rdata, 8'h00);
    checkOutput("reset_overflow", bus.overflow, 0);
    checkOutput("reset_underflow", bus.underflow, 0);

    applyStimulus(1, 8'hA5, 0, 0);
    checkOutput("first_fwft", bus.rdata, 8'hA5);
    applyStimulus(1, 8'h3C, 0, 0);
    applyStimulus(1, 8'hFF, 0, 0);
    checkOutput("order_count3", bus.count, 3);
    checkOutput("order_head0", bus.rdata, 8'hA5);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("order_head1", bus.rdata, 8'h3C);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("order_head2", bus.rdata, 8'hFF);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("order_empty", bus.empty, 1);
    checkOutput("order_rdata_zero", bus.rdata, 8'h00);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'h40 + 8'(i), 0, 0);
      checkOutput("wrap_data", bus.rdata, 32'h40 + 32'(i));
      checkOutput("wrap_count1", bus.count, 1);
      applyStimulus(0, 8'h00, 1, 0);
    end
    checkOutput("wrap_count0", bus.count, 0);
    checkOutput("wrap_underflow", bus.underflow, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'(i), 0, 0);
    end
    checkOutput("fill_full", bus.full, 1);
    checkOutput("fill_count", bus.count, 16);
    applyStimulus(1, 8'hEE, 0, 0);
    checkOutput("drop_overflow", bus.overflow, 1);
    checkOutput("drop_count", bus.count, 16);
    checkOutput("drop_head", bus.rdata, 8'h00);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("clr_overflow", bus.overflow, 0);

    applyStimulus(1, 8'h77, 1, 0);
    checkOutput("fullpp_count", bus.count, 16);
    checkOutput("fullpp_full", bus.full, 1);
    checkOutput("fullpp_overflow", bus.overflow, 0);
    for (int i = 1; i < 16; i++) begin
      checkOutput("drain_data", bus.rdata, 32'(i));
      applyStimulus(0, 8'h00, 1, 0);
    end
    checkOutput("drain_last", bus.rdata, 8'h77);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("drain_empty", bus.empty, 1);
    checkOutput("drain_underflow", bus.underflow, 0);

    applyStimulus(1, 8'h5A, 1, 0);
    checkOutput("emptypp_underflow", bus.underflow, 1);
    checkOutput("emptypp_count", bus.count, 1);
    checkOutput("emptypp_rdata", bus.rdata, 8'h5A);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("clr_underflow", bus.underflow, 0);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("pop_to_empty", bus.empty, 1);
    applyStimulus(0, 8'h00, 1, 1);
    checkOutput("set_beats_clr", bus.underflow, 1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'hC0 + 8'(i), 0, 0);
    end
    checkOutput("pre_reset_count", bus.count, 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_empty", bus.empty, 1);
    checkOutput("async_count", bus.count, 0);
    checkOutput("async_underflow", bus.underflow, 0);
    checkOutput("async_overflow", bus.overflow, 0);
    checkOutput("async_rdata", bus.rdata, 8'h00);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 8'h12, 0, 0);
    checkOutput("post_reset_data", bus.rdata, 8'h12);
    checkOutput("post_reset_count", bus.count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
